writeback_unit: RTL and testbench

Writeback stage of the pipeline: accepts one retiring instruction per handshake together with its 2-bit write-data select code, gathers the selected result (ALU, immediate, memory word or memory byte) and issues a single registered write to the register file. Memory loads are held in the stage until the data memory returns read data; the stage back-pressures the upstream pipeline while it waits. It consumes the select code produced by the register-file write-data controller and drives the register-file write port.

---
 rtl/writeback_unit_if.sv | 30 +++
 rtl/writeback_unit.sv | 115 +++++++++++
 tb/tb_writeback_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Handshake and bus signals of the writeback stage: upstream instruction, data-memory
// return path and register-file write port, bundled with master/slave views.
interface writeback_unit_if;
  logic        w_wb_valid;
  logic        w_wb_ready;
  logic [1:0]  w_wb_sel;
  logic        w_wb_reg_we;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_alu_result;
  logic [31:0] w_imm_value;
  logic [1:0]  w_mem_byte_lane;
  logic [31:0] w_mem_rdata;
  logic        w_mem_rvalid;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_wb_err;

  modport master (
    output w_wb_valid, w_wb_sel, w_wb_reg_we, w_wb_rd, w_alu_result, w_imm_value,
           w_mem_byte_lane, w_mem_rdata, w_mem_rvalid,
    input  w_wb_ready, w_rf_we, w_rf_waddr, w_rf_wdata, w_wb_err
  );

  modport slave (
    input  w_wb_valid, w_wb_sel, w_wb_reg_we, w_wb_rd, w_alu_result, w_imm_value,
           w_mem_byte_lane, w_mem_rdata, w_mem_rvalid,
    output w_wb_ready, w_rf_we, w_rf_waddr, w_rf_wdata, w_wb_err
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU/immediate/memory result and issues one registered
// register-file write per instruction. Optional load timeout under `WB_TIMEOUT_EN.
module writeback_unit #(
  parameter bit BYTE_SIGNED = 1'b1,
  parameter int MEM_TIMEOUT = 16
) (
  input logic            clock,
  input logic            reset_n,
  writeback_unit_if.slave bus
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state;
  logic        load_byte;
  logic [1:0]  load_lane;
  logic [4:0]  load_rd;
  logic        load_we;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_err;

  assign bus.w_wb_ready = (state == IDLE) && reset_n;
  assign bus.w_rf_we    = rf_we;
  assign bus.w_rf_waddr = rf_waddr;
  assign bus.w_rf_wdata = rf_wdata;

  always_comb begin
    lane_byte = 8'h00;
    case (load_lane)
      2'd0: lane_byte = bus.w_mem_rdata[7:0];
      2'd1: lane_byte = bus.w_mem_rdata[15:8];
      2'd2: lane_byte = bus.w_mem_rdata[23:16];
      2'd3: lane_byte = bus.w_mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    if (load_byte)
      load_data = {{24{BYTE_SIGNED & lane_byte[7]}}, lane_byte};
    else
      load_data = bus.w_mem_rdata;
  end

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);
  logic [7:0] wait_count;
  logic [7:0] wait_next;
  assign wait_next  = wait_count + 8'd1;
  assign bus.w_wb_err = wb_err;
`else
  assign bus.w_wb_err = 1'b0;
`endif

  // rvalid is only looked at while a load is outstanding; in WAIT_MEM it beats the timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      load_byte <= 1'b0;
      load_lane <= 2'd0;
      load_rd   <= 5'd0;
      load_we   <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'd0;
      wb_err    <= 1'b0;
`ifdef WB_TIMEOUT_EN
      wait_count <= 8'd0;
`endif
    end else begin
      rf_we  <= 1'b0;
      wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.w_wb_valid) begin
            if (bus.w_wb_sel[1]) begin
              rf_we    <= bus.w_wb_reg_we && (bus.w_wb_rd != 5'd0);
              rf_waddr <= bus.w_wb_rd;
              rf_wdata <= bus.w_wb_sel[0] ? bus.w_alu_result : bus.w_imm_value;
            end else begin
              load_byte <= bus.w_wb_sel[0];
              load_lane <= bus.w_mem_byte_lane;
              load_rd   <= bus.w_wb_rd;
              load_we   <= bus.w_wb_reg_we;
              state     <= WAIT_MEM;
`ifdef WB_TIMEOUT_EN
              wait_count <= 8'd0;
`endif
            end
          end
        end
        WAIT_MEM: begin
          if (bus.w_mem_rvalid) begin
            rf_we    <= load_we && (load_rd != 5'd0);
            rf_waddr <= load_rd;
            rf_wdata <= load_data;
            state    <= IDLE;
          end
`ifdef WB_TIMEOUT_EN
          else begin
            wait_count <= wait_next;
            if (wait_next == TIMEOUT_LIMIT) begin
              wb_err <= 1'b1;
              state  <= IDLE;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit; runs the timeout scenario when
// WB_TIMEOUT_EN is defined, otherwise checks that a load waits indefinitely.
module tb_writeback_unit;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  writeback_unit_if bus ();
  writeback_unit_if bus_u ();

  writeback_unit #(.BYTE_SIGNED(1'b1), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  writeback_unit #(.BYTE_SIGNED(1'b0), .MEM_TIMEOUT(4)) dut_u (
    .clock(clock), .reset_n(reset_n), .bus(bus_u)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.w_wb_valid = 0; bus.w_wb_sel = 2'b00; bus.w_wb_reg_we = 0; bus.w_wb_rd = 0;
    bus.w_alu_result = 0; bus.w_imm_value = 0; bus.w_mem_byte_lane = 0;
    bus.w_mem_rdata = 0; bus.w_mem_rvalid = 0;
    bus_u.w_wb_valid = 0; bus_u.w_wb_sel = 2'b00; bus_u.w_wb_reg_we = 0; bus_u.w_wb_rd = 0;
    bus_u.w_alu_result = 0; bus_u.w_imm_value = 0; bus_u.w_mem_byte_lane = 0;
    bus_u.w_mem_rdata = 0; bus_u.w_mem_rvalid = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    step();
    checks += 5;
    if (bus.w_wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.w_wb_ready); end
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", bus.w_rf_we); end
    if (bus.w_rf_waddr !== 5'd0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", bus.w_rf_waddr); end
    if (bus.w_rf_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus.w_rf_wdata); end
    if (bus.w_wb_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.w_wb_err); end
    reset_n = 1;
    step();
    checks++;
    if (bus.w_wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %b expected 1", bus.w_wb_ready); end
  endtask

  task automatic test_alu_stream();
    logic [31:0] vals [3] = '{32'hA, 32'hB, 32'hC};
    bus.w_wb_sel = 2'b11; bus.w_wb_reg_we = 1;
    for (int i = 0; i < 3; i++) begin
      bus.w_wb_valid = 1; bus.w_wb_rd = 5'(i + 1); bus.w_alu_result = vals[i];
      bus.w_imm_value = 32'hFFFF_0000;
      checks++;
      if (bus.w_wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready%0d: got %b expected 1", i, bus.w_wb_ready); end
      step();
      checks += 3;
      if (bus.w_rf_we !== 1'b1) begin errors++; $display("[TB] FAIL alu_we%0d: got %b expected 1", i, bus.w_rf_we); end
      if (bus.w_rf_waddr !== 5'(i + 1)) begin errors++; $display("[TB] FAIL alu_waddr%0d: got %0d expected %0d", i, bus.w_rf_waddr, i + 1); end
      if (bus.w_rf_wdata !== vals[i]) begin errors++; $display("[TB] FAIL alu_wdata%0d: got %h expected %h", i, bus.w_rf_wdata, vals[i]); end
    end
    bus.w_wb_valid = 0;
    step();
    checks++;
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL alu_we_end: got %b expected 0", bus.w_rf_we); end
  endtask

  task automatic test_word_load();
    bus.w_wb_valid = 1; bus.w_wb_sel = 2'b00; bus.w_wb_rd = 5; bus.w_wb_reg_we = 1;
    step();
    bus.w_wb_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (bus.w_wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL word_ready_low%0d: got %b expected 0", i, bus.w_wb_ready); end
      if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL word_early_we%0d: got %b expected 0", i, bus.w_rf_we); end
      if (i == 2) begin bus.w_mem_rvalid = 1; bus.w_mem_rdata = 32'hDEADBEEF; end
      step();
    end
    bus.w_mem_rvalid = 0;
    checks += 4;
    if (bus.w_rf_we !== 1'b1) begin errors++; $display("[TB] FAIL word_we: got %b expected 1", bus.w_rf_we); end
    if (bus.w_rf_waddr !== 5'd5) begin errors++; $display("[TB] FAIL word_waddr: got %0d expected 5", bus.w_rf_waddr); end
    if (bus.w_rf_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL word_wdata: got %h expected deadbeef", bus.w_rf_wdata); end
    if (bus.w_wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL word_ready_back: got %b expected 1", bus.w_wb_ready); end
    step();
    checks++;
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL word_single_pulse: got %b expected 0", bus.w_rf_we); end
  endtask

  task automatic test_byte_load();
    logic [31:0] exp [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    for (int lane = 0; lane < 4; lane++) begin
      bus.w_wb_valid = 1; bus.w_wb_sel = 2'b01; bus.w_wb_rd = 5'(10 + lane);
      bus.w_wb_reg_we = 1; bus.w_mem_byte_lane = 2'(lane);
      step();
      bus.w_wb_valid = 0; bus.w_mem_byte_lane = 2'(3 - lane);
      bus.w_mem_rvalid = 1; bus.w_mem_rdata = 32'h80FF7F01;
      step();
      bus.w_mem_rvalid = 0;
      checks += 3;
      if (bus.w_rf_we !== 1'b1) begin errors++; $display("[TB] FAIL byte_we%0d: got %b expected 1", lane, bus.w_rf_we); end
      if (bus.w_rf_waddr !== 5'(10 + lane)) begin errors++; $display("[TB] FAIL byte_waddr%0d: got %0d expected %0d", lane, bus.w_rf_waddr, 10 + lane); end
      if (bus.w_rf_wdata !== exp[lane]) begin errors++; $display("[TB] FAIL byte_wdata%0d: got %h expected %h", lane, bus.w_rf_wdata, exp[lane]); end
    end
    bus_u.w_wb_valid = 1; bus_u.w_wb_sel = 2'b01; bus_u.w_wb_rd = 4;
    bus_u.w_wb_reg_we = 1; bus_u.w_mem_byte_lane = 2'd3;
    step();
    bus_u.w_wb_valid = 0; bus_u.w_mem_rvalid = 1; bus_u.w_mem_rdata = 32'h80FF7F01;
    step();
    bus_u.w_mem_rvalid = 0;
    checks += 2;
    if (bus_u.w_rf_we !== 1'b1) begin errors++; $display("[TB] FAIL ubyte_we: got %b expected 1", bus_u.w_rf_we); end
    if (bus_u.w_rf_wdata !== 32'h00000080) begin errors++; $display("[TB] FAIL ubyte_wdata: got %h expected 00000080", bus_u.w_rf_wdata); end
  endtask

  task automatic test_suppression();
    bus.w_wb_valid = 1; bus.w_wb_sel = 2'b10; bus.w_wb_rd = 0; bus.w_wb_reg_we = 1;
    bus.w_imm_value = 32'h55; bus.w_alu_result = 32'h99;
    step();
    checks += 3;
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL supp_rd0_we: got %b expected 0", bus.w_rf_we); end
    if (bus.w_rf_waddr !== 5'd0) begin errors++; $display("[TB] FAIL supp_rd0_waddr: got %0d expected 0", bus.w_rf_waddr); end
    if (bus.w_rf_wdata !== 32'h55) begin errors++; $display("[TB] FAIL supp_rd0_wdata: got %h expected 55", bus.w_rf_wdata); end
    bus.w_wb_rd = 7; bus.w_wb_reg_we = 0; bus.w_imm_value = 32'h66;
    step();
    bus.w_wb_valid = 0;
    checks += 3;
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL supp_nowe_we: got %b expected 0", bus.w_rf_we); end
    if (bus.w_rf_waddr !== 5'd7) begin errors++; $display("[TB] FAIL supp_nowe_waddr: got %0d expected 7", bus.w_rf_waddr); end
    if (bus.w_rf_wdata !== 32'h66) begin errors++; $display("[TB] FAIL supp_nowe_wdata: got %h expected 66", bus.w_rf_wdata); end
    step();
    checks++;
    if (bus.w_rf_wdata !== 32'h66) begin errors++; $display("[TB] FAIL supp_hold_wdata: got %h expected 66", bus.w_rf_wdata); end
  endtask

  task automatic test_reset_mid_load();
    bus.w_wb_valid = 1; bus.w_wb_sel = 2'b00; bus.w_wb_rd = 9; bus.w_wb_reg_we = 1;
    step();
    bus.w_wb_valid = 0;
    checks++;
    if (bus.w_wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL midload_waiting: got %b expected 0", bus.w_wb_ready); end
    reset_n = 0;
    #1;
    checks += 4;
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL midload_rst_we: got %b expected 0", bus.w_rf_we); end
    if (bus.w_rf_waddr !== 5'd0) begin errors++; $display("[TB] FAIL midload_rst_waddr: got %0d expected 0", bus.w_rf_waddr); end
    if (bus.w_rf_wdata !== 32'd0) begin errors++; $display("[TB] FAIL midload_rst_wdata: got %h expected 0", bus.w_rf_wdata); end
    if (bus.w_wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL midload_rst_ready: got %b expected 0", bus.w_wb_ready); end
    bus.w_mem_rvalid = 1; bus.w_mem_rdata = 32'h12345678;
    step();
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL midload_no_write%0d: got %b expected 0", i, bus.w_rf_we); end
    end
    bus.w_mem_rvalid = 0;
    checks++;
    if (bus.w_wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL midload_ready: got %b expected 1", bus.w_wb_ready); end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    bus.w_wb_valid = 1; bus.w_wb_sel = 2'b00; bus.w_wb_rd = 6; bus.w_wb_reg_we = 1;
    step();
    bus.w_wb_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.w_wb_err !== 1'b0) begin errors++; $display("[TB] FAIL to_early_err%0d: got %b expected 0", i, bus.w_wb_err); end
    end
    step();
    checks += 3;
    if (bus.w_wb_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %b expected 1", bus.w_wb_err); end
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL to_no_write: got %b expected 0", bus.w_rf_we); end
    if (bus.w_wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_ready: got %b expected 1", bus.w_wb_ready); end
    bus.w_mem_rvalid = 1; bus.w_mem_rdata = 32'hCAFE0000;
    step();
    bus.w_mem_rvalid = 0;
    checks += 2;
    if (bus.w_wb_err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_pulse: got %b expected 0", bus.w_wb_err); end
    if (bus.w_rf_we !== 1'b0) begin errors++; $display("[TB] FAIL to_stray_rvalid: got %b expected 0", bus.w_rf_we); end
    bus.w_wb_valid = 1; bus.w_wb_rd = 8;
    step();
    bus.w_wb_valid = 0;
    for (int i = 0; i < 3; i++) step();
    bus.w_mem_rvalid = 1; bus.w_mem_rdata = 32'h0BADF00D;
    step();
    bus.w_mem_rvalid = 0;
    checks += 3;
    if (bus.w_rf_we !== 1'b1) begin errors++; $display("[TB] FAIL to_limit_we: got %b expected 1", bus.w_rf_we); end
    if (bus.w_rf_wdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL to_limit_wdata: got %h expected 0badf00d", bus.w_rf_wdata); end
    if (bus.w_wb_err !== 1'b0) begin errors++; $display("[TB] FAIL to_limit_err: got %b expected 0", bus.w_wb_err); end
  endtask
`else
  task automatic test_no_timeout();
    bus.w_wb_valid = 1; bus.w_wb_sel = 2'b00; bus.w_wb_rd = 6; bus.w_wb_reg_we = 1;
    step();
    bus.w_wb_valid = 0;
    for (int i = 0; i < 30; i++) step();
    checks += 2;
    if (bus.w_wb_err !== 1'b0) begin errors++; $display("[TB] FAIL nto_err: got %b expected 0", bus.w_wb_err); end
    if (bus.w_wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL nto_still_waiting: got %b expected 0", bus.w_wb_ready); end
    bus.w_mem_rvalid = 1; bus.w_mem_rdata = 32'h0BADF00D;
    step();
    bus.w_mem_rvalid = 0;
    checks += 2;
    if (bus.w_rf_we !== 1'b1) begin errors++; $display("[TB] FAIL nto_we: got %b expected 1", bus.w_rf_we); end
    if (bus.w_rf_wdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL nto_wdata: got %h expected 0badf00d", bus.w_rf_wdata); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_stream();
    test_word_load();
    test_byte_load();
    test_suppression();
    test_reset_mid_load();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
